mem_access_unit: RTL and testbench

Initiator-side memory access unit driving the byte-lane data RAM port (enable, write enable, 32-bit address, 4-bit byte select, 32-bit write data, combinational 32-bit read data, write committed on rising clock edge). It sits between the CPU MEM pipeline stage and the data RAM. It converts MIPS-style byte, halfword and word load/store requests into lane-aligned RAM accesses, and returns sign- or zero-extended load data through a valid/ready request and one-cycle response handshake.

---
 rtl/mem_access_unit.sv | 130 +++++++++++++
 tb/tb_mem_access_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Byte/half/word load-store unit between the MEM stage and a byte-lane data RAM.
// Optional MEM_ALIGN_CHECK_EN rejects misaligned half/word requests via the error path.
module mem_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [3:0]        ram_sel,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    typedef struct packed {
        logic              we;
        logic [2:0]        op;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
    } req_t;

    state_t state, state_n;
    req_t   q;
    logic   req_bad;
    logic   in_access;
    logic [3:0]       sel;
    logic [31:0]      wdata_rep;
    logic [31:0]      load_ext;
    logic [3:0][7:0]  rd_lanes;
    logic [7:0]       byte_v;
    logic [15:0]      half_v;

    always_comb begin
        req_bad = (req_op[1:0] == 2'b11);
`ifdef MEM_ALIGN_CHECK_EN
        if (req_op[1:0] == 2'b01 && req_addr[0])
            req_bad = 1'b1;
        if (req_op[1:0] == 2'b10 && req_addr[1:0] != 2'b00)
            req_bad = 1'b1;
`endif
    end

    // Lane decode works from the latched request so RAM outputs are glitch-free in ACCESS.
    always_comb begin
        sel       = 4'b0000;
        wdata_rep = q.wdata;
        case (q.op[1:0])
            2'b00: begin
                sel       = 4'b0001 << q.addr[1:0];
                wdata_rep = {4{q.wdata[7:0]}};
            end
            2'b01: begin
                sel       = q.addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{q.wdata[15:0]}};
            end
            2'b10: sel = 4'b1111;
            default: sel = 4'b0000;
        endcase
    end

    always_comb begin
        rd_lanes = ram_rdata;
        byte_v   = rd_lanes[q.addr[1:0]];
        half_v   = q.addr[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        case (q.op[1:0])
            2'b00:   load_ext = {{24{~q.op[2] & byte_v[7]}}, byte_v};
            2'b01:   load_ext = {{16{~q.op[2] & half_v[15]}}, half_v};
            default: load_ext = ram_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (req_valid) state_n = req_bad ? RESP : ACCESS;
            ACCESS:  state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q          <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    q        <= '{we: req_we, op: req_op, addr: req_addr, wdata: req_wdata};
                    resp_err <= req_bad;
                    if (req_bad)
                        resp_rdata <= '0;
                end
                ACCESS: resp_rdata <= q.we ? 32'h0 : load_ext;
                default: ;
            endcase
        end
    end

    // Reset gates the RAM strobes immediately so an in-flight store cannot commit.
    assign in_access  = (state == ACCESS);
    assign ram_en     = in_access & ~rst;
    assign ram_we     = ram_en & q.we;
    assign ram_addr   = {q.addr[ADDR_W-1:2], 2'b00};
    assign ram_sel    = in_access ? sel : 4'b0000;
    assign ram_wdata  = in_access ? wdata_rep : 32'h0;
    assign resp_valid = (state == RESP);
    assign req_ready  = (state == IDLE) & ~rst;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: bench-side RAM, shadow memory model, response queue.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        ram_en;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [3:0]  ram_sel;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem[256];
    logic [31:0] shadow[256];
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_sel(ram_sel), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    assign ram_rdata = mem[ram_addr[9:2]];

    always @(posedge clk) begin
        if (ram_en && ram_we)
            for (int k = 0; k < 4; k++)
                if (ram_sel[k])
                    mem[ram_addr[9:2]][8*k +: 8] = ram_wdata[8*k +: 8];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resp_valid) begin
            if (exp_q.size() == 0) begin
                chk("resp_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
            end
        end
    end

    function automatic logic is_bad(input logic [2:0] op, input logic [31:0] addr);
        logic b;
        b = (op[1:0] == 2'b11);
`ifdef MEM_ALIGN_CHECK_EN
        if (op[1:0] == 2'b01 && addr[0] != 1'b0) b = 1'b1;
        if (op[1:0] == 2'b10 && addr[1:0] != 2'b00) b = 1'b1;
`endif
        return b;
    endfunction

    function automatic logic [3:0] exp_sel(input logic [2:0] op, input logic [31:0] addr);
        case (op[1:0])
            2'b00:   return 4'(1 << addr[1:0]);
            2'b01:   return addr[1] ? 4'hC : 4'h3;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] exp_rep(input logic [2:0] op, input logic [31:0] wd);
        case (op[1:0])
            2'b00:   return {24'd0, wd[7:0]} * 32'h01010101;
            2'b01:   return {16'd0, wd[15:0]} * 32'h00010001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] addr);
        logic [31:0] w, v;
        w = shadow[addr[9:2]];
        case (op[1:0])
            2'b00: begin
                v = (w >> (8 * addr[1:0])) & 32'hFF;
                if (!op[2] && v[7]) v = v | 32'hFFFFFF00;
            end
            2'b01: begin
                v = (w >> (16 * addr[1])) & 32'hFFFF;
                if (!op[2] && v[15]) v = v | 32'hFFFF0000;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    task automatic do_req(input logic we, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata);
        int          guard = 0;
        logic        bad;
        logic [3:0]  s;
        logic [31:0] rep;
        exp_t        e;
        bad = is_bad(op, addr);
        s   = exp_sel(op, addr);
        rep = exp_rep(op, wdata);
        @(negedge clk);
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            chk("ready_timeout", 32'd0, 32'd1);
            return;
        end
        e.err   = bad;
        e.rdata = (bad || we) ? 32'h0 : model_load(op, addr);
        exp_q.push_back(e);
        req_valid = 1'b1; req_we = we; req_op = op; req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        if (bad) begin
            chk("err_ram_en", {31'd0, ram_en}, 32'd0);
            chk("err_resp_n1", {31'd0, resp_valid}, 32'd1);
        end else begin
            chk("acc_ram_en", {31'd0, ram_en}, 32'd1);
            chk("acc_ram_we", {31'd0, ram_we}, {31'd0, we});
            chk("acc_ram_addr", ram_addr, addr & 32'hFFFFFFFC);
            chk("acc_ram_sel", {28'd0, ram_sel}, {28'd0, s});
            if (we) begin
                chk("acc_ram_wdata", ram_wdata, rep);
                for (int k = 0; k < 4; k++)
                    if (s[k]) shadow[addr[9:2]][8*k +: 8] = rep[8*k +: 8];
            end
            @(negedge clk);
            chk("resp_n2", {31'd0, resp_valid}, 32'd1);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]    = (i * 32'h01030507) ^ 32'h5A5A0000;
            shadow[i] = (i * 32'h01030507) ^ 32'h5A5A0000;
        end
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_op = 3'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_ram_en", {31'd0, ram_en}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready_after", {31'd0, req_ready}, 32'd1);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_err", {31'd0, resp_err}, 32'd0);
        chk("rst_ram_addr", ram_addr, 32'h0);

        do_req(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);  // SW
        do_req(1'b0, 3'b010, 32'h100, 32'h0);         // LW
        do_req(1'b1, 3'b000, 32'h103, 32'h000000A5);  // SB
        do_req(1'b0, 3'b000, 32'h103, 32'h0);         // LB
        do_req(1'b0, 3'b100, 32'h103, 32'h0);         // LBU
        do_req(1'b1, 3'b001, 32'h102, 32'h00008001);  // SH
        do_req(1'b0, 3'b001, 32'h102, 32'h0);         // LH
        do_req(1'b0, 3'b101, 32'h102, 32'h0);         // LHU
        do_req(1'b0, 3'b010, 32'h100, 32'h0);         // LW
        do_req(1'b0, 3'b010, 32'h101, 32'h0);         // misaligned LW
        do_req(1'b0, 3'b001, 32'h101, 32'h0);         // misaligned LH
        do_req(1'b0, 3'b011, 32'h104, 32'h0);         // reserved load
        do_req(1'b1, 3'b111, 32'h104, 32'hFFFFFFFF);  // reserved store
        do_req(1'b0, 3'b010, 32'h104, 32'h0);         // reserved store left RAM intact

        // Reset lands during ACCESS of a store: no commit, no response.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_op = 3'b010;
        req_addr = 32'h200; req_wdata = 32'h12345678;
        @(posedge clk);
        #1 req_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("rst_acc_ram_en", {31'd0, ram_en}, 32'd0);
        chk("rst_acc_ram_we", {31'd0, ram_we}, 32'd0);
        chk("rst_acc_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_acc_resp", {31'd0, resp_valid}, 32'd0);
        chk("rst_acc_ready_back", {31'd0, req_ready}, 32'd1);
        do_req(1'b0, 3'b010, 32'h200, 32'h0);

        for (int i = 0; i < 24; i++) begin
            logic        we;
            logic [2:0]  op;
            logic [31:0] a;
            we = 1'($urandom_range(0, 1));
            op = 3'($urandom_range(0, 7));
            a  = 32'h300 + 32'($urandom_range(0, 31));
            do_req(we, op, a, $urandom);
        end

        repeat (4) @(negedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
